// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter: counting modes and FSM state encoding.
package step_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// Optional prescaler for step_counter: counts enabled div_clk edges 0..PRESCALE-1
// and raises tick on the edge where the count is at PRESCALE-1.
// Only instantiated when STEP_COUNTER_PRESCALE_EN is defined.
module step_prescaler #(
  parameter int PRESCALE = 2
) (
  input  logic div_clk,
  input  logic rst,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  // PRESCALE=1 degenerates to a single bit that never leaves 0, so tick follows en.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // Enabled-edge counter; en=0 freezes it, clear/load of the counter restarts it.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TERM) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_counter.sv
// Parametrised up/down step counter on the divided clock with wrap, saturate and
// one-shot modes, terminal-count pulse and one-shot done flag.
// Optional macro STEP_COUNTER_PRESCALE_EN adds an enabled-edge prescaler
// (step_prescaler) so the count steps once every PRESCALE enabled edges.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | counting normally (en/dir honoured)
// ST_DONE | one-shot finished; count frozen until clr, load or rst
module step_counter
  import step_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE     = 0,
  parameter int              PRESCALE = 2
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  // Arithmetic runs one bit wider so the bound compare never sees natural overflow.
  localparam logic [WIDTH:0] MAX_EXT = MAX_VAL[WIDTH:0];

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic [WIDTH:0]   count_ext, sum, diff, load_ext;
  logic             tick, step;

`ifdef STEP_COUNTER_PRESCALE_EN
  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .div_clk (div_clk),
    .rst     (rst),
    .en      (en),
    .sclr    (clr | load),
    .tick    (tick)
  );
`else
  // Without the prescaler every enabled edge steps; PRESCALE has no effect.
  assign tick = (PRESCALE > 0) ? 1'b1 : 1'b1;
`endif

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};
  assign sum       = count_ext + 1'b1;
  assign diff      = count_ext - 1'b1;
  assign step      = en && (state == ST_RUN) && tick;

  // Next-state decode: clr > load > step; tc is a pulse so it defaults low.
  always_comb begin
    count_n = count;
    tc_n    = 1'b0;
    state_n = state;
    if (clr) begin
      count_n = '0;
      state_n = ST_RUN;
    end else if (load) begin
      count_n = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
      state_n = ST_RUN;
    end else if (step) begin
      if (dir) begin
        if (count_ext == MAX_EXT) begin
          if (MODE == MODE_WRAP) begin
            count_n = '0;
            tc_n    = 1'b1;
          end else if (MODE == MODE_ONESHOT) begin
            // Already at the bound in RUN: finish on this first enabled step.
            tc_n    = 1'b1;
            state_n = ST_DONE;
          end
        end else begin
          count_n = sum[WIDTH-1:0];
          if (MODE != MODE_WRAP && sum == MAX_EXT) begin
            tc_n = 1'b1;
            if (MODE == MODE_ONESHOT) state_n = ST_DONE;
          end
        end
      end else begin
        if (count_ext == '0) begin
          if (MODE == MODE_WRAP) begin
            count_n = MAX_EXT[WIDTH-1:0];
            tc_n    = 1'b1;
          end else if (MODE == MODE_ONESHOT) begin
            tc_n    = 1'b1;
            state_n = ST_DONE;
          end
        end else begin
          count_n = diff[WIDTH-1:0];
          if (MODE != MODE_WRAP && diff == '0) begin
            tc_n = 1'b1;
            if (MODE == MODE_ONESHOT) state_n = ST_DONE;
          end
        end
      end
    end
  end

  // Registered state and outputs with asynchronous active-high reset.
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else begin
      count <= count_n;
      tc    <= tc_n;
      done  <= (state_n == ST_DONE);
      state <= state_n;
    end
  end

endmodule
